// File: rtl/wb_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_pkg
// Shared definitions for the Wishbone UART transmitter:
//   - register word offsets (wb_adr_i[3:2])
//   - STATUS register bit positions
//   - serializer state encoding
// -----------------------------------------------------------------------------
package wb_uart_tx_pkg;

   // Register word offsets
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   // STATUS bit indices
   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_LEVEL_LSB = 8;

   // Serializer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/wb_uart_tx_if.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_if
// Wishbone classic bus bundle for the UART transmitter.
//   master modport: drives adr/dat_i/we/sel/stb/cyc, receives dat_o/ack
//   slave  modport: the reverse
// -----------------------------------------------------------------------------
interface wb_uart_tx_if #(
   parameter int AW = 4
);
   logic [AW-1:0] wb_adr_i;
   logic [31:0]   wb_dat_i;
   logic [31:0]   wb_dat_o;
   logic          wb_we_i;
   logic [3:0]    wb_sel_i;
   logic          wb_stb_i;
   logic          wb_cyc_i;
   logic          wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_uart_tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read data (o_rdata is the head entry while
// not empty). Reusable by the receive path.
//   clock, reset      : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_wdata   : write request and data; ignored when full unless a pop
//                       happens in the same cycle
//   i_pop             : remove head entry; ignored when empty
//   o_rdata           : head entry
//   o_full, o_empty   : flags derived from the registered level
//   o_level           : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [PW:0]      r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   // Storage has no reset so it maps onto plain memory.
   always_ff @(posedge clock) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + 1'b1;
         end
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_full  = (r_level == (PW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;

endmodule

// File: rtl/wb_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_uart_tx
// Wishbone classic slave UART transmitter (8N1, LSB first).
//   clock  : system clock
//   reset  : synchronous active-high reset
//   wb     : Wishbone slave bundle (adr[3:2] selects TXDATA/STATUS/DIVISOR)
//   tx_o   : serial output, idle high
// STATUS: bit0 full, bit1 empty (FIFO empty and idle), bit2 busy, bit3 sticky
// overflow, FIFO level at bit8 upward (one extra bit so a full FIFO reads as
// FIFO_DEPTH rather than wrapping to 0).
// -----------------------------------------------------------------------------
module wb_uart_tx
   import wb_uart_tx_pkg::*;
#(
   parameter int CLK_DIV    = 208,
   parameter int FIFO_DEPTH = 16,
   parameter int AW         = 4
) (
   input  logic          clock,
   input  logic          reset,
   wb_uart_tx_if.slave   wb,
   output logic          tx_o
);
   localparam int          L       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

   // Bus side
   logic          r_ack;
   logic [31:0]   r_dat_o;
   logic [15:0]   r_div;
   logic          r_ovf;
   logic [AW-1:0] w_adr;
   logic [1:0]    w_reg;
   logic          w_req;
   logic          w_acc_wr;
   logic          w_push;
   logic          w_div_wr;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic [31:0]   w_status;
   logic [31:0]   w_rd_mux;

   // FIFO
   logic [7:0]    w_rdata;
   logic          w_full;
   logic          w_empty;
   logic [L:0]    w_level;
   logic          w_pop;

   // Serializer
   tx_state_t     r_state;
   logic [15:0]   r_bitcnt;
   logic [2:0]    r_bitidx;
   logic [7:0]    r_byte;
   logic [15:0]   r_div_lat;
   logic          r_tx;
   logic [2:0]    w_next_idx;

   logic          w_unused;

   assign w_adr = wb.wb_adr_i;
   assign w_reg = w_adr[3:2];

   // New request only when ack is low; the ack cycle itself commits the access.
   assign w_req    = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
   assign w_acc_wr = r_ack & wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i & wb.wb_sel_i[0];

   assign w_push    = w_acc_wr & (w_reg == REG_TXDATA);
   assign w_div_wr  = w_acc_wr & (w_reg == REG_DIVISOR);
   assign w_ovf_clr = w_acc_wr & (w_reg == REG_STATUS) & wb.wb_dat_i[ST_OVF];
   assign w_ovf_set = w_push & w_full & ~w_pop;

   // Pop relies on the registered empty flag, so push/pop on an empty FIFO never collide.
   assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) && (r_bitcnt == '0)));

   always_comb begin
      w_status                            = '0;
      w_status[ST_FULL]                   = w_full;
      w_status[ST_EMPTY]                  = w_empty & (r_state == IDLE);
      w_status[ST_BUSY]                   = (r_state != IDLE);
      w_status[ST_OVF]                    = r_ovf;
      w_status[ST_LEVEL_LSB +: L+1]       = w_level;
   end

   always_comb begin
      w_rd_mux = '0;
      unique case (w_reg)
         REG_STATUS:  w_rd_mux = w_status;
         REG_DIVISOR: w_rd_mux = {16'h0000, r_div};
         default:     w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ack   <= 1'b0;
         r_dat_o <= '0;
         r_div   <= DIV_RST;
         r_ovf   <= 1'b0;
      end else begin
         r_ack   <= w_req;
         r_dat_o <= w_req ? w_rd_mux : '0;
         if (w_div_wr) begin
            r_div <= (wb.wb_dat_i[15:0] == '0) ? 16'd1 : wb.wb_dat_i[15:0];
         end
         // Set has priority over a coincident clear.
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_dat_o;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (wb.wb_dat_i[7:0]),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_next_idx = r_bitidx + 3'd1;

   // Each bit lasts r_div_lat cycles: the counter is loaded with div-1 and the
   // state advances on the cycle it reads zero. The divisor is latched on START
   // entry so a DIVISOR write never stretches the frame in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bitcnt  <= '0;
         r_bitidx  <= '0;
         r_byte    <= '0;
         r_div_lat <= DIV_RST;
         r_tx      <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_byte    <= w_rdata;
                  r_div_lat <= r_div;
                  r_bitcnt  <= r_div - 16'd1;
                  r_tx      <= 1'b0;
                  r_state   <= START;
               end
            end
            START: begin
               if (r_bitcnt == '0) begin
                  r_bitcnt <= r_div_lat - 16'd1;
                  r_bitidx <= '0;
                  r_tx     <= r_byte[0];
                  r_state  <= DATA;
               end else begin
                  r_bitcnt <= r_bitcnt - 16'd1;
               end
            end
            DATA: begin
               if (r_bitcnt == '0) begin
                  r_bitcnt <= r_div_lat - 16'd1;
                  if (r_bitidx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bitidx <= w_next_idx;
                     r_tx     <= r_byte[w_next_idx];
                  end
               end else begin
                  r_bitcnt <= r_bitcnt - 16'd1;
               end
            end
            STOP: begin
               if (r_bitcnt == '0) begin
                  // Back-to-back frames: next start bit follows the stop bit directly.
                  if (w_pop) begin
                     r_byte    <= w_rdata;
                     r_div_lat <= r_div;
                     r_bitcnt  <= r_div - 16'd1;
                     r_tx      <= 1'b0;
                     r_state   <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_bitcnt <= r_bitcnt - 16'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_o = r_tx;

   assign w_unused = ^{wb.wb_dat_i[31:16], wb.wb_sel_i[3:1], w_adr[1:0]};

endmodule

// File: tb/tb_wb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_tx
// Directed bench for wb_uart_tx: bus tasks, cycle-accurate frame checks and a
// small serial receiver used for the FIFO overflow scenario.
// -----------------------------------------------------------------------------
module tb_wb_uart_tx;
   import wb_uart_tx_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic tx;

   wb_uart_tx_if #(.AW(4)) bus ();

   wb_uart_tx #(
      .CLK_DIV    (208),
      .FIFO_DEPTH (16),
      .AW         (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .wb    (bus),
      .tx_o  (tx)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One Wishbone access; returns in the cycle after the ack cycle (+1 time unit).
   task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      int n;
      @(posedge clock); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = wdat;
      bus.wb_sel_i = sel;
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!bus.wb_ack_o && n < 16);
      chk("ack_latency", n, 1);
      rdat = bus.wb_dat_o;
      @(posedge clock); #1;
      chk("ack_pulse", {31'd0, bus.wb_ack_o}, 0);
      chk("dat_idle", bus.wb_dat_o, 0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      $display("%s adr=0x%h dat=0x%08h", we ? "WR" : "RD", adr, we ? wdat : rdat);
   endtask

   task automatic wr(input logic [3:0] adr, input logic [31:0] d);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, d, 4'b0001, dummy);
   endtask

   task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string tag);
      logic [31:0] v;
      wb_xfer(1'b0, adr, 32'h0, 4'b0001, v);
      chk(tag, v, exp);
   endtask

   // Checks tx_o cycle by cycle for one 8N1 frame starting at the next edge.
   task automatic check_frame(input logic [7:0] b, input int div, input string tag);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < div; c++) begin
            @(posedge clock); #1;
            chk(tag, {31'd0, tx}, {31'd0, bits[k]});
         end
      end
   endtask

   // Serial receiver: samples mid-bit at mon_div cycles per bit.
   logic       mon_en  = 1'b0;
   int         mon_div = 20;
   logic [7:0] mon_b;
   logic [7:0] rx_q[$];

   initial begin
      forever begin
         @(posedge clock); #1;
         if (mon_en && tx === 1'b0) begin
            repeat (mon_div / 2) @(posedge clock);
            #1;
            for (int i = 0; i < 8; i++) begin
               repeat (mon_div) @(posedge clock);
               #1;
               mon_b[i] = tx;
            end
            repeat (mon_div) @(posedge clock);
            #1;
            rx_q.push_back(mon_b);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lows;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_tx", {31'd0, tx}, 1);
      chk("rst_ack", {31'd0, bus.wb_ack_o}, 0);
      chk("rst_dat", bus.wb_dat_o, 0);
      reset = 1'b0;
      rd(4'h4, 32'h0000_0002, "rst_status");
      rd(4'h8, 32'd208, "rst_divisor");
      rd(4'hC, 32'h0, "reserved_rd");
      rd(4'h0, 32'h0, "txdata_rd");
      chk("rst_tx_idle", {31'd0, tx}, 1);

      // Single frame 0x55 at 4 cycles/bit, start bit two cycles after ack
      wr(4'h8, 32'd4);
      wr(4'h0, 32'h55);
      chk("t2_gap", {31'd0, tx}, 1);
      fork
         check_frame(8'h55, 4, "t2_frame");
         begin
            repeat (8) @(posedge clock);
            rd(4'h4, 32'h0000_0004, "t2_busy");
         end
      join
      rd(4'h4, 32'h0000_0002, "t2_done");

      // Back-to-back frames, no idle gap
      wr(4'h0, 32'hA5);
      chk("t3_gap", {31'd0, tx}, 1);
      fork
         begin
            check_frame(8'hA5, 4, "t3_f1");
            check_frame(8'h3C, 4, "t3_f2");
         end
         wr(4'h0, 32'h3C);
      join
      rd(4'h4, 32'h0000_0002, "t3_done");

      // TXDATA write without sel[0] is ignored
      wb_xfer(1'b1, 4'h0, 32'h77, 4'b1110, mon_b);
      rd(4'h4, 32'h0000_0002, "sel0_ignored");

      // Overflow: long frames so only the first byte leaves during the writes
      wr(4'h8, 32'd20);
      mon_div = 20;
      rx_q.delete();
      mon_en = 1'b1;
      for (int k = 0; k < 17; k++) begin
         wr(4'h0, 32'h10 + k);
      end
      rd(4'h4, 32'h0000_1005, "t4_full");
      wr(4'h0, 32'h21);
      rd(4'h4, 32'h0000_100D, "t4_ovf");
      wr(4'h4, 32'h8);
      rd(4'h4, 32'h0000_1005, "t4_ovf_clr");
      n = 0;
      while (rx_q.size() < 17 && n < 5000) begin
         @(posedge clock);
         n++;
      end
      chk("t4_rx_count", rx_q.size(), 17);
      for (int k = 0; k < 17; k++) begin
         if (k < rx_q.size()) chk("t4_rx_byte", {24'd0, rx_q[k]}, 32'h10 + k);
      end
      repeat (300) @(posedge clock);
      #1;
      chk("t4_no_18th", rx_q.size(), 17);
      mon_en = 1'b0;
      rd(4'h4, 32'h0000_0002, "t4_done");

      // Reset mid-frame with a second byte queued
      wr(4'h8, 32'd4);
      wr(4'h0, 32'h00);
      wr(4'h0, 32'h00);
      repeat (7) @(posedge clock);
      #1;
      chk("t5_pre", {31'd0, tx}, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("t5_tx_high", {31'd0, tx}, 1);
      reset = 1'b0;
      lows = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clock); #1;
         if (tx !== 1'b1) lows++;
      end
      chk("t5_quiet", lows, 0);
      rd(4'h4, 32'h0000_0002, "t5_status");
      rd(4'h8, 32'd208, "t5_divisor");

      // Divisor: zero maps to one; a mid-frame change applies to the next frame
      wr(4'h8, 32'd0);
      rd(4'h8, 32'd1, "t6_div0");
      wr(4'h8, 32'd4);
      wr(4'h0, 32'h01);
      chk("t6_gap", {31'd0, tx}, 1);
      fork
         begin
            check_frame(8'h01, 4, "t6_f1");
            check_frame(8'h01, 8, "t6_f2");
         end
         begin
            wr(4'h0, 32'h01);
            wr(4'h8, 32'd8);
         end
      join
      rd(4'h8, 32'd8, "t6_div8");
      rd(4'h4, 32'h0000_0002, "t6_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
